// File: rtl/macu_pe.sv
// Signed weight-stationary MAC processing element with a double-buffered weight and a 3-stage pipeline.
// Define MACU_SAT_EN to saturate psum_out on overflow; by default the result wraps.
module macu_pe #(
  parameter int DW   = 8,
  parameter int ACCW = 20
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic signed [DW-1:0]   x_in,
  input  logic                   x_vld_in,
  input  logic signed [ACCW-1:0] psum_in,
  input  logic signed [DW-1:0]   w_in,
  input  logic                   w_ld_in,
  input  logic                   w_sw_in,
  output logic signed [DW-1:0]   x_out,
  output logic                   x_vld_out,
  output logic signed [DW-1:0]   w_out,
  output logic                   w_ld_out,
  output logic                   w_sw_out,
  output logic signed [ACCW-1:0] psum_out,
  output logic                   psum_vld,
  output logic                   ovf
);

  if (ACCW < 2*DW) begin : g_accw_check
    $error("macu_pe: ACCW must be at least 2*DW");
  end

`ifdef MACU_SAT_EN
  function automatic logic signed [ACCW-1:0] fn_sat(input logic signed [ACCW:0] sum);
    logic signed [ACCW-1:0] res;
    if (sum[ACCW] != sum[ACCW-1])
      res = sum[ACCW] ? {1'b1, {(ACCW-1){1'b0}}} : {1'b0, {(ACCW-1){1'b1}}};
    else
      res = sum[ACCW-1:0];
    return res;
  endfunction
`endif

  logic signed [DW-1:0]     r_w_shadow, r_w_active;
  logic signed [DW-1:0]     r_x_d, r_w_d;
  logic                     r_x_vld_d, r_w_ld_d, r_w_sw_d;

  logic signed [DW-1:0]     r_x_p0, r_w_p0;
  logic signed [ACCW-1:0]   r_psum_p0;
  logic                     r_vld_p0;
  logic signed [2*DW-1:0]   r_prod_p1;
  logic signed [ACCW-1:0]   r_psum_p1;
  logic                     r_vld_p1;
  logic signed [ACCW-1:0]   r_psum_p2;
  logic                     r_ovf_p2;
  logic                     r_vld_p2;

  logic signed [2*DW-1:0]   w_prod;
  logic signed [ACCW:0]     w_sum;
  logic signed [ACCW-1:0]   w_res;
  logic                     w_ovf;

  // Weight double buffer and unconditional neighbour forwarding
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_w_shadow <= '0;
      r_w_active <= '0;
      r_x_d      <= '0;
      r_w_d      <= '0;
      r_x_vld_d  <= 1'b0;
      r_w_ld_d   <= 1'b0;
      r_w_sw_d   <= 1'b0;
    end else begin
      if (w_ld_in) r_w_shadow <= w_in;
      if (w_sw_in) r_w_active <= r_w_shadow;
      r_x_d     <= x_in;
      r_w_d     <= w_in;
      r_x_vld_d <= x_vld_in;
      r_w_ld_d  <= w_ld_in;
      r_w_sw_d  <= w_sw_in;
    end
  end

  assign w_prod = $signed({{DW{r_x_p0[DW-1]}}, r_x_p0}) * $signed({{DW{r_w_p0[DW-1]}}, r_w_p0});
  assign w_sum  = $signed({r_psum_p1[ACCW-1], r_psum_p1})
                + $signed({{(ACCW+1-2*DW){r_prod_p1[2*DW-1]}}, r_prod_p1});
  assign w_ovf  = w_sum[ACCW] ^ w_sum[ACCW-1];
`ifdef MACU_SAT_EN
  assign w_res  = fn_sat(w_sum);
`else
  assign w_res  = w_sum[ACCW-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x_p0    <= '0;
      r_w_p0    <= '0;
      r_psum_p0 <= '0;
      r_vld_p0  <= 1'b0;
      r_prod_p1 <= '0;
      r_psum_p1 <= '0;
      r_vld_p1  <= 1'b0;
      r_psum_p2 <= '0;
      r_ovf_p2  <= 1'b0;
      r_vld_p2  <= 1'b0;
    end else begin
      // S1: capture operands with the weight active before this edge
      r_vld_p0 <= x_vld_in;
      if (x_vld_in) begin
        r_x_p0    <= x_in;
        r_w_p0    <= r_w_active;
        r_psum_p0 <= psum_in;
      end
      // S2: product
      r_vld_p1 <= r_vld_p0;
      if (r_vld_p0) begin
        r_prod_p1 <= w_prod;
        r_psum_p1 <= r_psum_p0;
      end
      // S3: accumulate; result and flag hold across bubbles
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) begin
        r_psum_p2 <= w_res;
        r_ovf_p2  <= w_ovf;
      end
    end
  end

  assign x_out     = r_x_d;
  assign x_vld_out = r_x_vld_d;
  assign w_out     = r_w_d;
  assign w_ld_out  = r_w_ld_d;
  assign w_sw_out  = r_w_sw_d;
  assign psum_out  = r_psum_p2;
  assign psum_vld  = r_vld_p2;
  assign ovf       = r_ovf_p2 & r_vld_p2;

endmodule

// File: tb/tb_macu_pe.sv
// Directed testbench for macu_pe (DW=8, ACCW=20) with immediate-assertion checks.
// Define MACU_SAT_EN for both RTL and bench to exercise the saturating build.
module tb_macu_pe;
  localparam int DW   = 8;
  localparam int ACCW = 20;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic signed [DW-1:0]   x_in;
  logic                   x_vld_in;
  logic signed [ACCW-1:0] psum_in;
  logic signed [DW-1:0]   w_in;
  logic                   w_ld_in;
  logic                   w_sw_in;
  logic signed [DW-1:0]   x_out;
  logic                   x_vld_out;
  logic signed [DW-1:0]   w_out;
  logic                   w_ld_out;
  logic                   w_sw_out;
  logic signed [ACCW-1:0] psum_out;
  logic                   psum_vld;
  logic                   ovf;

  int n_chk = 0;
  int n_err = 0;

  macu_pe #(.DW(DW), .ACCW(ACCW)) dut (
    .clk(clk), .rst_n(rst_n),
    .x_in(x_in), .x_vld_in(x_vld_in), .psum_in(psum_in),
    .w_in(w_in), .w_ld_in(w_ld_in), .w_sw_in(w_sw_in),
    .x_out(x_out), .x_vld_out(x_vld_out), .w_out(w_out),
    .w_ld_out(w_ld_out), .w_sw_out(w_sw_out),
    .psum_out(psum_out), .psum_vld(psum_vld), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".x_out"},     x_out,     0);
    chk({tag, ".x_vld_out"}, x_vld_out, 0);
    chk({tag, ".w_out"},     w_out,     0);
    chk({tag, ".w_ld_out"},  w_ld_out,  0);
    chk({tag, ".w_sw_out"},  w_sw_out,  0);
    chk({tag, ".psum_out"},  psum_out,  0);
    chk({tag, ".psum_vld"},  psum_vld,  0);
    chk({tag, ".ovf"},       ovf,       0);
  endtask

  int exp3 [6] = '{2, 4, 6, 28, 35, 42};
  int m_shadow, m_active, m_tmp, exp_ps, ps_tmp, pre_ps;
  logic qv [3];
  int   qp [3];

  initial begin
    // Test 1: reset with busy inputs, then idle after release
    rst_n = 1'b0;
    x_in = 8'sd5; x_vld_in = 1'b1; psum_in = 20'sd7;
    w_in = 8'sd3; w_ld_in = 1'b1; w_sw_in = 1'b1;
    tick; tick;
    chk_all_zero("rst");
    x_in = '0; x_vld_in = 1'b0; psum_in = '0; w_in = '0; w_ld_in = 1'b0; w_sw_in = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("idle.psum_vld", psum_vld, 0);
    end
    chk("idle.psum_out", psum_out, 0);

    // Test 2: basic MAC, weight -3, x=5, psum 100
    w_in = -8'sd3; w_ld_in = 1'b1; tick;
    w_ld_in = 1'b0; w_sw_in = 1'b1; tick;
    w_sw_in = 1'b0; w_in = '0;
    x_in = 8'sd5; psum_in = 20'sd100; x_vld_in = 1'b1; tick;
    chk("mac.x_out", x_out, 5);
    chk("mac.x_vld_out", x_vld_out, 1);
    x_vld_in = 1'b0; tick;
    chk("mac.vld_early", psum_vld, 0);
    tick;
    chk("mac.psum_vld", psum_vld, 1);
    chk("mac.psum_out", psum_out, 85);
    chk("mac.ovf", ovf, 0);
    tick;
    chk("mac.vld_after", psum_vld, 0);
    chk("mac.hold", psum_out, 85);

    // Test 3: double buffer, swap alongside x=3 uses the old weight
    w_in = 8'sd2; w_ld_in = 1'b1; tick;
    w_ld_in = 1'b0; w_sw_in = 1'b1; tick;
    for (int k = 1; k <= 8; k++) begin
      x_vld_in = (k <= 6);
      x_in     = 8'(k);
      psum_in  = 20'(10 * k);
      w_ld_in  = (k == 1);
      w_in     = (k == 1) ? 8'sd7 : 8'sd0;
      w_sw_in  = (k == 3);
      tick;
      if (k >= 3) begin
        chk($sformatf("dbuf.vld%0d", k - 2), psum_vld, 1);
        chk($sformatf("dbuf.psum%0d", k - 2), psum_out, 10 * (k - 2) + exp3[k - 3]);
      end
    end
    x_vld_in = 1'b0; w_ld_in = 1'b0; w_sw_in = 1'b0;

    // Test 4: load+swap in one cycle, then extremes
    w_in = -8'sd128; w_ld_in = 1'b1; w_sw_in = 1'b1; tick;
    w_ld_in = 1'b0; w_sw_in = 1'b0;
    x_in = 8'sd1; psum_in = 20'sd0; x_vld_in = 1'b1; tick;
    x_vld_in = 1'b0; w_sw_in = 1'b1; tick;
    chk("ext.bubble_a", psum_vld, 0);
    w_sw_in = 1'b0;
    x_in = -8'sd128; psum_in = 20'sd524287; x_vld_in = 1'b1; tick;
    chk("ldsw.vld", psum_vld, 1);
    chk("ldsw.old_shadow", psum_out, 7);
    x_in = 8'sd127; psum_in = -20'sd524288; tick;
    chk("ext.bubble_c", psum_vld, 0);
    chk("ext.hold", psum_out, 7);
    x_vld_in = 1'b0; tick;
    chk("ext.pos.vld", psum_vld, 1);
    chk("ext.pos.ovf", ovf, 1);
`ifdef MACU_SAT_EN
    chk("ext.pos.psum", psum_out, 524287);
`else
    chk("ext.pos.psum", psum_out, -507905);
`endif
    tick;
    chk("ext.neg.vld", psum_vld, 1);
    chk("ext.neg.ovf", ovf, 1);
`ifdef MACU_SAT_EN
    chk("ext.neg.psum", psum_out, -524288);
    exp_ps = -524288;
`else
    chk("ext.neg.psum", psum_out, 508032);
    exp_ps = 508032;
`endif
    tick;
    chk("ext.idle.vld", psum_vld, 0);
    chk("ext.idle.ovf", ovf, 0);
    chk("ext.idle.hold", psum_out, exp_ps);

    // Test 5: random pass-through and bubbles against a reference model
    m_shadow = -128; m_active = -128;
    for (int i = 0; i < 3; i++) begin
      qv[i] = 1'b0; qp[i] = 0;
    end
    for (int i = 0; i < 43; i++) begin
      x_in    = 8'($urandom);
      w_in    = 8'($urandom);
      ps_tmp  = int'($urandom_range(0, 2000)) - 1000;
      psum_in = 20'(ps_tmp);
      x_vld_in = (i < 40) && ($urandom_range(0, 3) != 0);
      w_ld_in  = (i < 40) && ($urandom_range(0, 1) != 0);
      w_sw_in  = (i < 40) && ($urandom_range(0, 1) != 0);
      tick;
      chk("pt.x_out",     x_out,     x_in);
      chk("pt.x_vld_out", x_vld_out, x_vld_in);
      chk("pt.w_out",     w_out,     w_in);
      chk("pt.w_ld_out",  w_ld_out,  w_ld_in);
      chk("pt.w_sw_out",  w_sw_out,  w_sw_in);
      qv[2] = qv[1]; qp[2] = qp[1];
      qv[1] = qv[0]; qp[1] = qp[0];
      qv[0] = x_vld_in;
      qp[0] = ps_tmp + int'(x_in) * m_active;
      m_tmp = m_shadow;
      if (w_ld_in) m_shadow = int'(w_in);
      if (w_sw_in) m_active = m_tmp;
      if (qv[2]) exp_ps = qp[2];
      chk("rnd.psum_vld", psum_vld, qv[2]);
      chk("rnd.psum_out", psum_out, exp_ps);
      chk("rnd.ovf", ovf, 0);
    end
    x_vld_in = 1'b0; w_ld_in = 1'b0; w_sw_in = 1'b0;

    // Test 6: reset with two results in flight
    pre_ps = 10 + 3 * m_active;
    x_in = 8'sd3; psum_in = 20'sd10; x_vld_in = 1'b1; tick;
    x_in = 8'sd4; psum_in = 20'sd20; tick;
    x_in = 8'sd5; psum_in = 20'sd30; tick;
    chk("mrst.pre.vld", psum_vld, 1);
    chk("mrst.pre.psum", psum_out, pre_ps);
    x_vld_in = 1'b0; x_in = '0; psum_in = '0; w_in = '0;
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("mrst");
    tick;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("mrst.no_result", psum_vld, 0);
    end
    x_in = 8'sd9; psum_in = 20'sd55; x_vld_in = 1'b1; tick;
    x_vld_in = 1'b0; tick; tick;
    chk("mrst.post.vld", psum_vld, 1);
    chk("mrst.post.psum", psum_out, 55);
    chk("mrst.post.ovf", ovf, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
